// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch types and geometry: state encoding, cache-line sizes and the PC-to-line-index slice.
// Latency: n/a. Backpressure: n/a.
package pc_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_STREAM,
        S_DROP
    } fetch_state_t;

    localparam int LINE_BYTES     = 64;
    localparam int INSTS_PER_LINE = 16;
    localparam int INST_W         = 32;
    localparam int PC_INDEX_W     = 19;
    localparam int LINE_W         = LINE_BYTES * 8;
    localparam int SLOT_W         = $clog2(INSTS_PER_LINE);

    function automatic logic [PC_INDEX_W-1:0] pc_to_index(input logic [63:0] pc);
        return pc[24:6];
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_line_buf.sv
// Line buffer: holds one 512-bit fetched line and the slot pointer, and muxes out the current instruction.
// Latency: load/advance visible the cycle after. Backpressure: slot only moves on advance.
module fetch_line_buf
    import pc_fetch_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [LINE_W-1:0] load_dat,
    input  logic [SLOT_W-1:0] load_slot,
    input  logic              advance,
    input  logic              flush,
    output logic [SLOT_W-1:0] slot,
    output logic [INST_W-1:0] inst,
    output logic              last
);

    logic [LINE_W-1:0] r_line;
    logic [SLOT_W-1:0] r_slot;

    // Line contents are don't-care until the first load, so no reset here.
    always_ff @(posedge clock) begin
        if (load) begin
            r_line <= load_dat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_slot <= '0;
        end else if (flush) begin
            r_slot <= '0;
        end else if (load) begin
            r_slot <= load_slot;
        end else if (advance) begin
            r_slot <= r_slot + SLOT_W'(1);
        end
    end

    assign slot = r_slot;
    assign inst = r_line[INST_W*r_slot +: INST_W];
    assign last = (r_slot == SLOT_W'(INSTS_PER_LINE - 1));

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch requester: issues line requests to the arbiter, captures the burst, streams instructions to decode.
// Latency: 1 cycle request after enable, 1 cycle done->first inst. Backpressure: inst held while !inst_ready.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int              PC_W    = 64,
    parameter logic [PC_W-1:0] BOOT_PC = PC_W'(64'h0000_0000_0000_1000)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_enable,
    input  logic                  redirect_valid,
    input  logic [PC_W-1:0]       redirect_target,
    output logic                  pc_index_valid,
    output logic [PC_INDEX_W-1:0] pc_index,
    input  logic                  pc_index_ready,
    input  logic [LINE_W-1:0]     pc_read_inst,
    input  logic                  pc_operation_done,
    output logic                  inst_valid,
    output logic [INST_W-1:0]     inst,
    output logic [PC_W-1:0]       inst_pc,
    input  logic                  inst_ready
);

    localparam int HI_W = PC_W - 6;

    fetch_state_t          r_state;
    logic [PC_W-1:0]       r_fetch_pc;
    logic                  r_pc_index_valid;
    logic [PC_INDEX_W-1:0] r_pc_index;
    logic                  r_inst_valid;
    logic                  r_drop_pending;

    logic                  w_fire;
    logic                  w_accept;
    logic [PC_W-1:0]       w_redir_pc;
    logic [HI_W-1:0]       w_line_hi_next;
    logic [PC_W-1:0]       w_next_line_pc;
    logic                  w_load;
    logic                  w_advance;
    logic [SLOT_W-1:0]     w_slot;
    logic [INST_W-1:0]     w_inst;
    logic                  w_last;
    logic                  w_unused;

    assign w_fire         = r_pc_index_valid & pc_index_ready;
    assign w_accept       = r_inst_valid & inst_ready;
    assign w_redir_pc     = {redirect_target[PC_W-1:2], 2'b00};
    assign w_line_hi_next = r_fetch_pc[PC_W-1:6] + HI_W'(1);
    assign w_next_line_pc = {w_line_hi_next, 6'b000000};
    assign w_unused       = ^redirect_target[1:0];

    assign w_load    = (r_state == S_WAIT) & pc_operation_done & ~redirect_valid;
    assign w_advance = (r_state == S_STREAM) & w_accept & ~redirect_valid;

    fetch_line_buf u_line_buf (
        .clock     (clock),
        .reset     (reset),
        .load      (w_load),
        .load_dat  (pc_read_inst),
        .load_slot (r_fetch_pc[5:2]),
        .advance   (w_advance),
        .flush     (redirect_valid),
        .slot      (w_slot),
        .inst      (w_inst),
        .last      (w_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_fetch_pc       <= BOOT_PC;
            r_pc_index_valid <= 1'b0;
            r_pc_index       <= '0;
            r_inst_valid     <= 1'b0;
            r_drop_pending   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= w_redir_pc;
                        if (fetch_enable) begin
                            r_state          <= S_REQ;
                            r_pc_index_valid <= 1'b1;
                            r_pc_index       <= pc_to_index(64'(w_redir_pc));
                        end
                    end else if (fetch_enable) begin
                        r_state          <= S_REQ;
                        r_pc_index_valid <= 1'b1;
                        r_pc_index       <= pc_to_index(64'(r_fetch_pc));
                    end
                end

                // The arbiter may already have latched the index, so a redirect never withdraws it.
                S_REQ: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= w_redir_pc;
                        if (w_fire) begin
                            r_pc_index_valid <= 1'b0;
                            r_drop_pending   <= 1'b0;
                            r_state          <= S_DROP;
                        end else begin
                            r_drop_pending <= 1'b1;
                        end
                    end else if (w_fire) begin
                        r_pc_index_valid <= 1'b0;
                        r_drop_pending   <= 1'b0;
                        r_state          <= r_drop_pending ? S_DROP : S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= w_redir_pc;
                        if (pc_operation_done) begin
                            r_state          <= S_REQ;
                            r_pc_index_valid <= 1'b1;
                            r_pc_index       <= pc_to_index(64'(w_redir_pc));
                        end else begin
                            r_state <= S_DROP;
                        end
                    end else if (pc_operation_done) begin
                        r_state      <= S_STREAM;
                        r_inst_valid <= 1'b1;
                    end
                end

                S_STREAM: begin
                    if (redirect_valid) begin
                        r_fetch_pc   <= w_redir_pc;
                        r_inst_valid <= 1'b0;
                        if (fetch_enable) begin
                            r_state          <= S_REQ;
                            r_pc_index_valid <= 1'b1;
                            r_pc_index       <= pc_to_index(64'(w_redir_pc));
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_accept && w_last) begin
                        r_fetch_pc   <= w_next_line_pc;
                        r_inst_valid <= 1'b0;
                        if (fetch_enable) begin
                            r_state          <= S_REQ;
                            r_pc_index_valid <= 1'b1;
                            r_pc_index       <= pc_to_index(64'(w_next_line_pc));
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_DROP: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= w_redir_pc;
                    end else if (pc_operation_done) begin
                        if (fetch_enable) begin
                            r_state          <= S_REQ;
                            r_pc_index_valid <= 1'b1;
                            r_pc_index       <= pc_to_index(64'(r_fetch_pc));
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pc_index_valid = r_pc_index_valid;
    assign pc_index       = r_pc_index;
    assign inst_valid     = r_inst_valid;
    assign inst           = r_inst_valid ? w_inst : '0;
    assign inst_pc        = r_inst_valid ? {r_fetch_pc[PC_W-1:6], w_slot, 2'b00} : '0;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: table-driven first fetch, then hand-written redirect/backpressure/disable sequences.
module tb_pc_fetch_ctrl;

    logic         clock = 1'b0;
    logic         reset;
    logic         fetch_enable;
    logic         redirect_valid;
    logic [63:0]  redirect_target;
    logic         pc_index_valid;
    logic [18:0]  pc_index;
    logic         pc_index_ready;
    logic [511:0] pc_read_inst;
    logic         pc_operation_done;
    logic         inst_valid;
    logic [31:0]  inst;
    logic [63:0]  inst_pc;
    logic         inst_ready;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    pc_fetch_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .fetch_enable      (fetch_enable),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .pc_index_valid    (pc_index_valid),
        .pc_index          (pc_index),
        .pc_index_ready    (pc_index_ready),
        .pc_read_inst      (pc_read_inst),
        .pc_operation_done (pc_operation_done),
        .inst_valid        (inst_valid),
        .inst              (inst),
        .inst_pc           (inst_pc),
        .inst_ready        (inst_ready)
    );

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        done;
        logic        irdy;
        logic        e_piv;
        logic [18:0] e_idx;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [63:0] e_pc;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mv(input logic fe, input logic rdy, input logic done, input logic irdy,
                                input logic e_piv, input logic [18:0] e_idx, input logic e_iv,
                                input logic [31:0] e_inst, input logic [63:0] e_pc);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.done = done; v.irdy = irdy;
        v.e_piv = e_piv; v.e_idx = e_idx; v.e_iv = e_iv; v.e_inst = e_inst; v.e_pc = e_pc;
        return v;
    endfunction

    function automatic logic [511:0] mk_line(input logic [31:0] base);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) begin
            l[32*k +: 32] = base + 32'(k);
        end
        return l;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_out(input string tag, input logic e_piv, input logic [18:0] e_idx,
                           input logic e_iv, input logic [31:0] e_inst, input logic [63:0] e_pc);
        chk({tag, ".piv"}, 64'(pc_index_valid), 64'(e_piv));
        if (e_piv) chk({tag, ".idx"}, 64'(pc_index), 64'(e_idx));
        chk({tag, ".iv"}, 64'(inst_valid), 64'(e_iv));
        if (e_iv) begin
            chk({tag, ".inst"}, 64'(inst), 64'(e_inst));
            chk({tag, ".pc"}, inst_pc, e_pc);
        end
    endtask

    task automatic drv(input logic fe, input logic rdy, input logic done, input logic irdy,
                       input logic rv, input logic [63:0] tgt, input logic [511:0] dat);
        fetch_enable      = fe;
        pc_index_ready    = rdy;
        pc_operation_done = done;
        inst_ready        = irdy;
        redirect_valid    = rv;
        redirect_target   = tgt;
        pc_read_inst      = dat;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [511:0] line_a, line_junk, line_c, line_d, line_e, line_f;
        logic [7:0]   pat;
        int           slot;

        line_a    = mk_line(32'h1000_0000);
        line_junk = mk_line(32'hDEAD_0000);
        line_c    = mk_line(32'h2000_0000);
        line_d    = mk_line(32'h3100_0000);
        line_e    = mk_line(32'hBAD0_0000);
        line_f    = mk_line(32'h3000_0000);

        tbl[0] = mv(1, 0, 0, 0, 1, 19'h40, 0, 0, 0);
        tbl[1] = mv(1, 0, 0, 0, 1, 19'h40, 0, 0, 0);
        tbl[2] = mv(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 3; i < 7; i++) tbl[i] = mv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7] = mv(1, 0, 1, 0, 0, 0, 1, 32'h1000_0000, 64'h1000);
        for (int j = 0; j < 15; j++)
            tbl[8+j] = mv(1, 0, 0, 1, 0, 0, 1, 32'h1000_0000 + 32'(j + 1), 64'h1000 + 64'(4 * (j + 1)));
        tbl[23] = mv(1, 0, 0, 1, 1, 19'h41, 0, 0, 0);

        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, '0);
        drv(0, 0, 0, 0, 0, 0, '0);
        reset = 1'b0;
        chk("rst.piv", 64'(pc_index_valid), 64'd0);
        chk("rst.idx", 64'(pc_index), 64'd0);
        chk("rst.iv", 64'(inst_valid), 64'd0);
        chk("rst.inst", 64'(inst), 64'd0);
        chk("rst.pc", inst_pc, 64'd0);

        // First fetch from BOOT_PC, driven from the table
        for (int i = 0; i < 24; i++) begin
            drv(tbl[i].fe, tbl[i].rdy, tbl[i].done, tbl[i].irdy, 0, 0, line_a);
            chk_out($sformatf("tbl%0d", i), tbl[i].e_piv, tbl[i].e_idx, tbl[i].e_iv, tbl[i].e_inst, tbl[i].e_pc);
        end

        // Redirect while REQ is pending: index held until fire, old burst dropped, reissue at new line
        drv(1, 0, 0, 0, 1, 64'h2034, line_junk);
        chk_out("reqrd0", 1, 19'h41, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, line_junk);
        chk_out("reqrd1", 1, 19'h41, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0, line_junk);
        chk_out("reqrd2", 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, line_junk);
        chk_out("reqrd3", 0, 0, 0, 0, 0);
        drv(1, 0, 1, 0, 0, 0, line_junk);
        chk_out("reqrd4", 1, 19'h80, 0, 0, 0);

        // Unaligned target: first slot 13
        drv(1, 1, 0, 0, 0, 0, line_junk);
        chk_out("unal0", 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, line_junk);
        drv(1, 0, 1, 0, 0, 0, line_c);
        chk_out("unal1", 0, 0, 1, 32'h2000_000D, 64'h2034);
        drv(1, 0, 0, 1, 0, 0, line_c);
        chk_out("unal2", 0, 0, 1, 32'h2000_000E, 64'h2038);
        drv(1, 0, 0, 1, 0, 0, line_c);
        chk_out("unal3", 0, 0, 1, 32'h2000_000F, 64'h203C);
        drv(1, 0, 0, 1, 0, 0, line_c);
        chk_out("unal4", 1, 19'h81, 0, 0, 0);

        // Backpressure with toggling inst_ready
        drv(1, 1, 0, 0, 0, 0, line_junk);
        drv(1, 0, 1, 0, 0, 0, line_d);
        chk_out("bp0", 0, 0, 1, 32'h3100_0000, 64'h2040);
        pat  = 8'b0110_0101;
        slot = 0;
        for (int c = 0; c < 8; c++) begin
            drv(1, 0, 0, pat[c], 0, 0, line_junk);
            if (pat[c]) slot++;
            chk_out($sformatf("bp%0d", c + 1), 0, 0, 1, 32'h3100_0000 + 32'(slot), 64'h2040 + 64'(4 * slot));
        end

        // Redirect out of STREAM
        drv(1, 0, 0, 0, 1, 64'h5000, line_junk);
        chk_out("strd", 1, 19'h140, 0, 0, 0);

        // Redirect while WAIT: old data never shown, new request only after old done
        drv(1, 1, 0, 0, 0, 0, line_junk);
        chk_out("wtrd0", 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, line_junk);
        drv(1, 0, 0, 0, 1, 64'h3000, line_junk);
        chk_out("wtrd1", 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, line_junk);
        chk_out("wtrd2", 0, 0, 0, 0, 0);
        drv(1, 0, 1, 0, 0, 0, line_e);
        chk_out("wtrd3", 1, 19'hC0, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0, line_junk);
        chk_out("wtrd4", 0, 0, 0, 0, 0);
        drv(1, 0, 1, 0, 0, 0, line_f);
        chk_out("wtrd5", 0, 0, 1, 32'h3000_0000, 64'h3000);

        // fetch_enable dropped mid-line: line finishes, then IDLE
        for (int k = 1; k <= 16; k++) begin
            drv(k <= 4, 0, 0, 1, 0, 0, line_junk);
            if (k < 16)
                chk_out($sformatf("dis%0d", k), 0, 0, 1, 32'h3000_0000 + 32'(k), 64'h3000 + 64'(4 * k));
            else
                chk_out("dis16", 0, 0, 0, 0, 0);
        end
        for (int k = 0; k < 3; k++) begin
            drv(0, 0, 0, 0, 0, 0, line_junk);
            chk_out($sformatf("idle%0d", k), 0, 0, 0, 0, 0);
        end
        drv(1, 0, 0, 0, 0, 0, line_junk);
        chk_out("reen", 1, 19'hC1, 0, 0, 0);

        // Reset mid-burst, late done ignored
        drv(1, 1, 0, 0, 0, 0, line_junk);
        chk_out("mrst0", 0, 0, 0, 0, 0);
        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, line_junk);
        reset = 1'b0;
        chk_out("mrst1", 0, 0, 0, 0, 0);
        chk("mrst1.pc", inst_pc, 64'd0);
        drv(0, 0, 1, 0, 0, 0, line_f);
        chk_out("mrst2", 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, line_junk);
        chk_out("mrst3", 1, 19'h40, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
